// File: rtl/polymul_ring_engine.sv
// Schoolbook polynomial multiplier over Z_Q, optionally reduced mod x^P - x - 1, accumulating into RAM c.
// Latency: 2 + N + 2*T + 2*F cycles from the start-sampling edge to done (2 cycles for a rejected start).
// Backpressure: none; start is sampled only in IDLE and ignored while busy. RAMs are fixed 1-cycle read latency.
//
// Ports: clk, rst_n (async active-low); start/mode/dega/degb command (latched on accept);
//        busy/done/err/deg status; a_addr/a_rdata, b_addr/b_rdata operand RAM reads;
//        c_raddr/c_rdata, c_waddr/c_wdata/c_we result RAM read-modify-write.
module polymul_ring_engine #(
  parameter int CW = 13,
  parameter int AW = 11,
  parameter int Q  = 4591,
  parameter int P  = 757
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] dega,
  input  logic [AW-1:0] degb,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] deg,
  output logic [AW-1:0] a_addr,
  input  logic [CW-1:0] a_rdata,
  output logic [AW-1:0] b_addr,
  input  logic [CW-1:0] b_rdata,
  output logic [AW-1:0] c_raddr,
  input  logic [CW-1:0] c_rdata,
  output logic [AW-1:0] c_waddr,
  output logic [CW-1:0] c_wdata,
  output logic          c_we
);

  typedef enum logic [2:0] {
    IDLE, CHECK, CLEAR, RD, WR, F2RD, F2WR, DONE
  } state_t;

  localparam logic [AW:0]     P_W = (AW+1)'(P);
  localparam logic [2*CW:0]   Q_W = (2*CW+1)'(Q);

  state_t state, state_nx;

  logic                mode_r;
  logic [AW-1:0]       dega_r, degb_r;
  logic [AW-1:0]       i_r, j_r;
  logic [AW:0]         n_r, nlim_r;
  logic [AW-1:0]       deg_r;
  logic [AW-1:0]       waddr_r;   // address of the current term's primary RMW
  logic                fold_r;    // current term needs the x^(k-P+1) fold
  logic                err_r;
  logic [2*CW-1:0]     prod_r;    // product kept for the fold write

  logic [AW:0]         degsum;
  logic                reject;
  logic [AW:0]         k;
  logic                k_fold;
  logic [AW-1:0]       k_addr;
  logic                last_term;
  logic                clear_last;
  logic [2*CW-1:0]     prod_cur;

  // Full reduction of a sum that is at most (Q-1) + (2^CW-1)^2.
  function automatic logic [CW-1:0] mod_q(input logic [2*CW:0] x);
    return CW'(x % Q_W);
  endfunction

  assign degsum     = {1'b0, dega_r} + {1'b0, degb_r};
  assign reject     = mode_r ? (({1'b0, dega_r} >= P_W) || ({1'b0, degb_r} >= P_W))
                             : degsum[AW];
  assign k          = {1'b0, i_r} + {1'b0, j_r};
  assign k_fold     = mode_r && (k >= P_W);
  assign k_addr     = AW'(k_fold ? (k - P_W) : k);
  assign last_term  = (i_r == dega_r) && (j_r == degb_r);
  assign clear_last = (n_r == nlim_r - 1'b1);
  assign prod_cur   = (2*CW)'(a_rdata) * (2*CW)'(b_rdata);
  assign deg        = deg_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= 1'b0;
      dega_r  <= '0;
      degb_r  <= '0;
      i_r     <= '0;
      j_r     <= '0;
      n_r     <= '0;
      nlim_r  <= '0;
      deg_r   <= '0;
      waddr_r <= '0;
      fold_r  <= 1'b0;
      err_r   <= 1'b0;
      prod_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r <= mode;
            dega_r <= dega;
            degb_r <= degb;
          end
        end
        CHECK: begin
          err_r <= reject;
          n_r   <= '0;
          i_r   <= '0;
          j_r   <= '0;
          if (!reject) begin
            nlim_r <= mode_r ? P_W : degsum + 1'b1;
            deg_r  <= mode_r ? AW'(P - 1) : degsum[AW-1:0];
          end
        end
        CLEAR: n_r <= n_r + 1'b1;
        RD: begin
          waddr_r <= k_addr;
          fold_r  <= k_fold;
        end
        default: ;
      endcase

      if (state == WR) begin
        prod_r <= prod_cur;
      end

      // Step to the next term once the current one has finished all its writes.
      if ((state == WR && !fold_r) || state == F2WR) begin
        if (j_r == degb_r) begin
          j_r <= '0;
          i_r <= i_r + 1'b1;
        end else begin
          j_r <= j_r + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    c_raddr  = '0;
    c_waddr  = '0;
    c_wdata  = '0;
    c_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = reject ? DONE : CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        c_we    = 1'b1;
        c_waddr = n_r[AW-1:0];
        if (clear_last) state_nx = RD;
      end
      RD: begin
        busy     = 1'b1;
        a_addr   = i_r;
        b_addr   = j_r;
        c_raddr  = k_addr;
        state_nx = WR;
      end
      WR: begin
        busy    = 1'b1;
        c_we    = 1'b1;
        c_waddr = waddr_r;
        c_wdata = mod_q((2*CW+1)'(c_rdata) + (2*CW+1)'(prod_cur));
        if (fold_r)         state_nx = F2RD;
        else if (last_term) state_nx = DONE;
        else                state_nx = RD;
      end
      F2RD: begin
        // x^k = x^(k-P) + x^(k-P+1); the second half lands one address up.
        busy     = 1'b1;
        c_raddr  = waddr_r + 1'b1;
        state_nx = F2WR;
      end
      F2WR: begin
        busy     = 1'b1;
        c_we     = 1'b1;
        c_waddr  = waddr_r + 1'b1;
        c_wdata  = mod_q((2*CW+1)'(c_rdata) + (2*CW+1)'(prod_r));
        state_nx = last_term ? DONE : RD;
      end
      DONE: begin
        done     = 1'b1;
        err      = err_r;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_polymul_ring_engine.sv
module tb_polymul_ring_engine;
  localparam int CW = 13;
  localparam int AW = 11;
  localparam int Q  = 4591;
  localparam int P  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] dega = '0;
  logic [AW-1:0] degb = '0;
  logic          busy, done, err;
  logic [AW-1:0] deg;
  logic [AW-1:0] a_addr, b_addr, c_raddr, c_waddr;
  logic [CW-1:0] a_rdata, b_rdata, c_rdata, c_wdata;
  logic          c_we;

  logic [CW-1:0] a_mem [0:2047];
  logic [CW-1:0] b_mem [0:2047];
  logic [CW-1:0] c_mem [0:2047];

  int checks = 0;
  int failures = 0;

  polymul_ring_engine #(.CW(CW), .AW(AW), .Q(Q), .P(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dega(dega), .degb(degb),
    .busy(busy), .done(done), .err(err), .deg(deg),
    .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_raddr(c_raddr), .c_rdata(c_rdata), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_we(c_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rdata <= a_mem[a_addr];
    b_rdata <= b_mem[b_addr];
    c_rdata <= c_mem[c_raddr];
    if (c_we) c_mem[c_waddr] <= c_wdata;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one command and follows it to done; optionally pulses start mid-run
  // and scrambles dega after acceptance to show both are ignored.
  task automatic run_op(input bit m, input int da, input int db, input bit pulse_mid,
                        output int cyc, output int we_cnt, output bit err_seen, output bit busy1);
    @(negedge clk);
    mode = m; dega = AW'(da); degb = AW'(db); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dega = '1;
    cyc = 1;
    we_cnt = int'(c_we);
    busy1 = busy;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      we_cnt += int'(c_we);
      if (pulse_mid && cyc == 4) start = 1'b1;
      if (cyc == 5) start = 1'b0;
    end
    err_seen = err;
    check("done_within_budget", done, 1);
  endtask

  int cyc, we_cnt;
  bit err_seen, busy1;
  longint pr [0:8];
  int d1, d2;
  bit b6, b7;

  initial begin
    for (int n = 0; n < 2048; n++) begin
      a_mem[n] = '0;
      b_mem[n] = '0;
    end

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_deg", deg, 0);
    check("rst_c_we", c_we, 0);
    check("rst_c_waddr", c_waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain product (1+2x)(3+4x) = 3 + 10x + 8x^2
    a_mem[0] = 1; a_mem[1] = 2; b_mem[0] = 3; b_mem[1] = 4;
    run_op(0, 1, 1, 0, cyc, we_cnt, err_seen, busy1);
    check("plain_latency", cyc, 13);
    check("plain_err", err_seen, 0);
    check("plain_busy_c1", busy1, 1);
    check("plain_c0", c_mem[0], 3);
    check("plain_c1", c_mem[1], 10);
    check("plain_c2", c_mem[2], 8);
    check("plain_deg", deg, 2);
    check("plain_we_count", we_cnt, 3 + 4);
    @(negedge clk);
    check("plain_done_one_cycle", done, 0);
    check("plain_busy_after", busy, 0);

    // Modular wrap: (-1)(-1) = 1
    a_mem[0] = 4590; b_mem[0] = 4590;
    run_op(0, 0, 0, 0, cyc, we_cnt, err_seen, busy1);
    check("wrap_latency", cyc, 5);
    check("wrap_c0", c_mem[0], 1);
    check("wrap_deg", deg, 0);

    // Ring fold P=5: x^4 * x^2 = x^6 = x^2 + x
    for (int n = 0; n < 8; n++) begin a_mem[n] = '0; b_mem[n] = '0; end
    a_mem[4] = 1; b_mem[2] = 1;
    run_op(1, 4, 2, 0, cyc, we_cnt, err_seen, busy1);
    check("fold_latency", cyc, 2 + 5 + 2*15 + 2*3);
    check("fold_we_count", we_cnt, 5 + 15 + 3);
    check("fold_c0", c_mem[0], 0);
    check("fold_c1", c_mem[1], 1);
    check("fold_c2", c_mem[2], 1);
    check("fold_c3", c_mem[3], 0);
    check("fold_c4", c_mem[4], 0);
    check("fold_deg", deg, 4);

    // Random full-degree operands against a mod (x^5 - x - 1, 4591) reference
    for (int n = 0; n < 5; n++) begin
      a_mem[n] = CW'($urandom_range(0, Q-1));
      b_mem[n] = CW'($urandom_range(0, Q-1));
    end
    for (int n = 0; n < 9; n++) pr[n] = 0;
    for (int ii = 0; ii < 5; ii++)
      for (int jj = 0; jj < 5; jj++)
        pr[ii+jj] += longint'(a_mem[ii]) * longint'(b_mem[jj]);
    for (int kk = 8; kk >= 5; kk--) begin
      pr[kk-5] += pr[kk];
      pr[kk-4] += pr[kk];
    end
    run_op(1, 4, 4, 0, cyc, we_cnt, err_seen, busy1);
    check("rand_latency", cyc, 2 + 5 + 2*25 + 2*10);
    for (int n = 0; n < 5; n++) check($sformatf("rand_c%0d", n), c_mem[n], pr[n] % Q);

    // Degree reject in ring mode: dega = P
    run_op(1, P, 0, 0, cyc, we_cnt, err_seen, busy1);
    check("rej_ring_latency", cyc, 2);
    check("rej_ring_err", err_seen, 1);
    check("rej_ring_no_we", we_cnt, 0);
    @(negedge clk);
    check("rej_ring_busy_after", busy, 0);
    check("rej_ring_err_one_cycle", err, 0);

    run_op(1, 4, P, 0, cyc, we_cnt, err_seen, busy1);
    check("rej_ring_degb_err", err_seen, 1);

    // Plain-mode degree sum overflow and its largest accepted neighbour
    run_op(0, 2047, 1, 0, cyc, we_cnt, err_seen, busy1);
    check("rej_plain_latency", cyc, 2);
    check("rej_plain_err", err_seen, 1);
    check("rej_plain_no_we", we_cnt, 0);
    run_op(0, 2047, 0, 0, cyc, we_cnt, err_seen, busy1);
    check("max_plain_err", err_seen, 0);
    check("max_plain_latency", cyc, 2 + 2048 + 2*2048);
    check("max_plain_deg", deg, 2047);

    // Reset asserted in the middle of the term loop
    @(negedge clk);
    mode = 1'b1; dega = 4; degb = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_deg", deg, 0);
    check("midrst_a_addr", a_addr, 0);
    check("midrst_c_raddr", c_raddr, 0);
    check("midrst_c_we", c_we, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh run after reset, with a start pulse while busy
    for (int n = 0; n < 8; n++) begin a_mem[n] = '0; b_mem[n] = '0; end
    a_mem[0] = 1; a_mem[1] = 2; b_mem[0] = 3; b_mem[1] = 4;
    run_op(0, 1, 1, 1, cyc, we_cnt, err_seen, busy1);
    check("post_rst_latency", cyc, 13);
    check("post_rst_c0", c_mem[0], 3);
    check("post_rst_c1", c_mem[1], 10);
    check("post_rst_c2", c_mem[2], 8);
    @(negedge clk);
    check("pulse_ignored_busy", busy, 0);

    // Start held high: one operation per IDLE visit, back-to-back after done
    @(negedge clk);
    mode = 1'b0; dega = 0; degb = 0; start = 1'b1;
    d1 = 0; d2 = 0; b6 = 1'b0; b7 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 6) b6 = busy;
      if (c == 7) b7 = busy;
    end
    start = 1'b0;
    check("held_first_done", d1, 5);
    check("held_second_done", d2, 11);
    check("held_idle_gap", b6, 0);
    check("held_restart_busy", b7, 1);
    repeat (10) @(negedge clk);
    check("held_drained", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
